isa_dma_chan: RTL and testbench

//  Single-channel 8237-style DMA engine servicing a peripheral's DRQ/DACK on the ISA-side bus
//  (e.g. floppy controller on channel 2). Arbitrates for the bus (HRQ/HLDA), then runs fly-by

---
 rtl/isa_dma_pkg.sv | 25 ++
 rtl/isa_dma_ctr.sv | 36 +++
 rtl/isa_dma_chan.sv | 207 ++++++++++++++++++++
 tb/tb_isa_dma_chan.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_dma_pkg.sv
// Shared definitions for the single-channel ISA DMA engine: FSM states,
// program-register addresses, mode bit positions and the mode reset value.
package isa_dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_ADDR = 3'd2,
    S_XFER = 3'd3,
    S_UPD  = 3'd4
  } state_t;

  localparam logic [1:0] RA_ADDR  = 2'd0;
  localparam logic [1:0] RA_COUNT = 2'd1;
  localparam logic [1:0] RA_PAGE  = 2'd2;
  localparam logic [1:0] RA_MODE  = 2'd3;

  localparam int unsigned MB_DIR  = 0;
  localparam int unsigned MB_AUTO = 1;
  localparam int unsigned MB_DEC  = 2;
  localparam int unsigned MB_MASK = 3;

  localparam logic [3:0] MODE_RST = 4'b1000;

endpackage

// File: rtl/isa_dma_ctr.sv
// Base/current 16-bit register pair. A load writes both; reload copies base
// into current; step moves current by one (wrapping at 16 bits).
module isa_dma_ctr (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [15:0] i_ldata,
  input  logic        i_step,
  input  logic        i_dec,
  input  logic        i_reload,
  output logic [15:0] o_base,
  output logic [15:0] o_cur
);

  logic [15:0] r_base;
  logic [15:0] r_cur;

  // Register load wins over any same-cycle step/reload from the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base <= '0;
      r_cur  <= '0;
    end else if (i_load) begin
      r_base <= i_ldata;
      r_cur  <= i_ldata;
    end else if (i_reload) begin
      r_cur  <= r_base;
    end else if (i_step) begin
      r_cur  <= i_dec ? (r_cur - 16'd1) : (r_cur + 16'd1);
    end
  end

  assign o_base = r_base;
  assign o_cur  = r_cur;

endmodule

// File: rtl/isa_dma_chan.sv
// 8237-style single-channel fly-by DMA engine: bus request/ack handshake,
// address/AEN/DACK generation, paired I/O + memory strobes and terminal count.
// Optional macro DMA_STATUS_EN adds a sticky tc_seen flag at mode address bit 8.
module isa_dma_chan
  import isa_dma_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned ADDR_W        = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reg_wr,
  input  logic [1:0]        reg_addr,
  input  logic [15:0]       reg_wdata,
  output logic [15:0]       reg_rdata,
  input  logic              drq,
  output logic              hrq,
  input  logic              hlda,
  output logic              dack_n,
  output logic              tc,
  output logic              aen,
  output logic [ADDR_W-1:0] a,
  output logic              ior_n,
  output logic              iow_n,
  output logic              memr_n,
  output logic              memw_n
);

  localparam int unsigned PW  = ADDR_W - 16;
  localparam int unsigned SCW = $clog2(STROBE_CYCLES + 1);
  localparam logic [SCW-1:0] SC_LAST = SCW'(STROBE_CYCLES - 1);

  state_t          r_state;
  state_t          w_next;
  logic [SCW-1:0]  r_scnt;
  logic [3:0]      r_mode;
  logic [PW-1:0]   r_page;
  logic [15:0]     w_addr_cur;
  logic [15:0]     w_cnt_cur;
  logic            w_wr_addr;
  logic            w_wr_cnt;
  logic            w_wr_page;
  logic            w_wr_mode;
  logic            w_upd;
  logic            w_last;
  logic            w_reload;
  logic            w_step;
  logic [7:0]      w_status;

  assign w_wr_addr = reg_wr && (reg_addr == RA_ADDR);
  assign w_wr_cnt  = reg_wr && (reg_addr == RA_COUNT);
  assign w_wr_page = reg_wr && (reg_addr == RA_PAGE);
  assign w_wr_mode = reg_wr && (reg_addr == RA_MODE);
  assign w_upd     = (r_state == S_UPD);
  assign w_last    = (w_cnt_cur == 16'd0);
  assign w_reload  = w_upd && w_last && r_mode[MB_AUTO];
  assign w_step    = w_upd && !w_reload;

  isa_dma_ctr u_addr (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_wr_addr),
    .i_ldata  (reg_wdata),
    .i_step   (w_step),
    .i_dec    (r_mode[MB_DEC]),
    .i_reload (w_reload),
    .o_base   (),
    .o_cur    (w_addr_cur)
  );

  isa_dma_ctr u_count (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_wr_cnt),
    .i_ldata  (reg_wdata),
    .i_step   (w_step),
    .i_dec    (1'b1),
    .i_reload (w_reload),
    .o_base   (),
    .o_cur    (w_cnt_cur)
  );

  // Mode register; terminal count without autoinit masks the channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= MODE_RST;
    end else if (w_wr_mode) begin
      r_mode <= reg_wdata[3:0];
    end else if (w_upd && w_last && !r_mode[MB_AUTO]) begin
      r_mode[MB_MASK] <= 1'b1;
    end
  end

  // Page register supplies the address bits above the 16-bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_page <= '0;
    end else if (w_wr_page) begin
      r_page <= reg_wdata[PW-1:0];
    end
  end

  // Strobe-width counter, running only while in XFER.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scnt <= '0;
    end else if (r_state == S_XFER) begin
      r_scnt <= r_scnt + SCW'(1);
    end else begin
      r_scnt <= '0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and bus outputs, all decoded from the current state.
  always_comb begin
    w_next = r_state;
    hrq    = 1'b0;
    aen    = 1'b0;
    dack_n = 1'b1;
    tc     = 1'b0;
    ior_n  = 1'b1;
    iow_n  = 1'b1;
    memr_n = 1'b1;
    memw_n = 1'b1;
    a      = '0;
    case (r_state)
      S_IDLE: begin
        if (drq && !r_mode[MB_MASK]) w_next = S_REQ;
      end
      S_REQ: begin
        hrq = 1'b1;
        if (!drq)      w_next = S_IDLE;
        else if (hlda) w_next = S_ADDR;
      end
      S_ADDR: begin
        hrq    = 1'b1;
        aen    = 1'b1;
        dack_n = 1'b0;
        a      = {r_page, w_addr_cur};
        w_next = S_XFER;
      end
      S_XFER: begin
        hrq    = 1'b1;
        aen    = 1'b1;
        dack_n = 1'b0;
        a      = {r_page, w_addr_cur};
        tc     = w_last;
        if (r_mode[MB_DIR]) begin
          memr_n = 1'b0;
          iow_n  = 1'b0;
        end else begin
          ior_n  = 1'b0;
          memw_n = 1'b0;
        end
        if (r_scnt == SC_LAST) w_next = S_UPD;
      end
      S_UPD: begin
        hrq    = 1'b1;
        aen    = 1'b1;
        dack_n = 1'b0;
        a      = {r_page, w_addr_cur};
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

`ifdef DMA_STATUS_EN
  logic r_tc_seen;

  // Sticky terminal-count flag; a new TC beats a simultaneous clearing write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tc_seen <= 1'b0;
    end else if (tc) begin
      r_tc_seen <= 1'b1;
    end else if (w_wr_mode) begin
      r_tc_seen <= 1'b0;
    end
  end

  assign w_status = {7'b0, r_tc_seen};
`else
  assign w_status = '0;
`endif

  // Register read-back mux.
  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      RA_ADDR:  reg_rdata = w_addr_cur;
      RA_COUNT: reg_rdata = w_cnt_cur;
      RA_PAGE:  reg_rdata = {{(16 - PW){1'b0}}, r_page};
      default:  reg_rdata = {w_status, 4'b0, r_mode};
    endcase
  end

endmodule

// File: tb/tb_isa_dma_chan.sv
// Self-checking bench for isa_dma_chan: transaction-level model of the byte
// sequence a programmed block should produce, plus a bus monitor.
module tb_isa_dma_chan;

  localparam int SC = 2;

  logic        clk;
  logic        rst_n;
  logic        reg_wr;
  logic [1:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic [15:0] reg_rdata;
  logic        drq;
  logic        hrq;
  logic        hlda;
  logic        dack_n;
  logic        tc;
  logic        aen;
  logic [19:0] a;
  logic        ior_n, iow_n, memr_n, memw_n;

  int checks   = 0;
  int failures = 0;

  isa_dma_chan #(.STROBE_CYCLES(SC), .ADDR_W(20)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .reg_wr    (reg_wr),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .drq       (drq),
    .hrq       (hrq),
    .hlda      (hlda),
    .dack_n    (dack_n),
    .tc        (tc),
    .aen       (aen),
    .a         (a),
    .ior_n     (ior_n),
    .iow_n     (iow_n),
    .memr_n    (memr_n),
    .memw_n    (memw_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus arbiter: grants hold two clocks after the request appears.
  logic       hlda_en;
  logic [1:0] sh;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) sh <= 2'b00;
    else        sh <= {sh[0], hrq};
  end
  assign hlda = hlda_en & hrq & sh[1];

  // Bus monitor: one record per strobe burst.
  logic [19:0] q_a[$];
  logic [3:0]  q_code[$];
  logic        q_tc[$];
  int          q_len[$];
  logic        prev_low;
  logic        low;
  int          run;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_low = 1'b0;
      run      = 0;
    end else begin
      low = !(ior_n & iow_n & memr_n & memw_n);
      if (low) begin
        checks++;
        if (aen !== 1'b1) begin
          failures++;
          $display("FAIL strobe_without_aen aen=%b required=1", aen);
        end
        checks++;
        if ((!memr_n && !memw_n) || (!ior_n && !iow_n)) begin
          failures++;
          $display("FAIL strobe_conflict strobes=%b%b%b%b", ior_n, iow_n, memr_n, memw_n);
        end
        if (!prev_low) begin
          q_a.push_back(a);
          q_code.push_back({ior_n, iow_n, memr_n, memw_n});
          q_tc.push_back(tc);
          run = 0;
        end
        run++;
      end else if (prev_low) begin
        q_len.push_back(run);
      end
      prev_low = low;
    end
  end

  task automatic clear_q();
    q_a.delete(); q_code.delete(); q_tc.delete(); q_len.delete();
  endtask

  task automatic wr(input logic [1:0] ad, input logic [15:0] d);
    @(negedge clk);
    reg_wr = 1'b1; reg_addr = ad; reg_wdata = d;
    @(negedge clk);
    reg_wr = 1'b0;
  endtask

  task automatic rd(input logic [1:0] ad, output logic [15:0] d);
    reg_addr = ad;
    #1;
    d = reg_rdata;
  endtask

  // Program one block, let it run to completion, compare against the model.
  task automatic run_block(input string name, input logic [15:0] base, input logic [15:0] cnt,
                           input logic [3:0] pg, input logic [3:0] mode);
    int n;
    int cyc;
    logic [15:0] d;
    logic [15:0] ea;
    logic [15:0] exp_addr;
    logic [15:0] exp_cnt;
    logic [3:0]  exp_code;
    drq = 1'b0;
    wr(2'd0, base);
    wr(2'd1, cnt);
    wr(2'd2, {12'b0, pg});
    wr(2'd3, {12'b0, mode});
    @(negedge clk); #1;
    clear_q();
    n = int'(cnt) + 1;
    drq = 1'b1;
    cyc = 0;
    while (q_len.size() < n && cyc < 40 * n + 40) begin
      @(negedge clk); #1;
      cyc++;
    end
    drq = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (q_len.size() != n) begin
      failures++;
      $display("FAIL %s_byte_count got=%0d required=%0d", name, q_len.size(), n);
    end
    exp_code = mode[0] ? 4'b1001 : 4'b0110;
    for (int i = 0; i < n && i < q_len.size(); i++) begin
      ea = mode[2] ? (base - 16'(i)) : (base + 16'(i));
      checks++;
      if (q_a[i] !== {pg, ea}) begin
        failures++;
        $display("FAIL %s_addr[%0d] got=%h required=%h", name, i, q_a[i], {pg, ea});
      end
      checks++;
      if (q_code[i] !== exp_code) begin
        failures++;
        $display("FAIL %s_strobes[%0d] got=%b required=%b", name, i, q_code[i], exp_code);
      end
      checks++;
      if (q_tc[i] !== (i == n - 1)) begin
        failures++;
        $display("FAIL %s_tc[%0d] got=%b required=%b", name, i, q_tc[i], (i == n - 1));
      end
      checks++;
      if (q_len[i] != SC) begin
        failures++;
        $display("FAIL %s_strobe_len[%0d] got=%0d required=%0d", name, i, q_len[i], SC);
      end
    end
    exp_addr = mode[1] ? base : (mode[2] ? (base - 16'(n)) : (base + 16'(n)));
    exp_cnt  = mode[1] ? cnt : 16'hFFFF;
    rd(2'd0, d);
    checks++;
    if (d !== exp_addr) begin
      failures++;
      $display("FAIL %s_cur_addr got=%h required=%h", name, d, exp_addr);
    end
    rd(2'd1, d);
    checks++;
    if (d !== exp_cnt) begin
      failures++;
      $display("FAIL %s_cur_count got=%h required=%h", name, d, exp_cnt);
    end
    rd(2'd3, d);
    checks++;
    if (d[3:0] !== (mode[1] ? mode : (mode | 4'b1000))) begin
      failures++;
      $display("FAIL %s_mode got=%b required=%b", name, d[3:0], (mode[1] ? mode : (mode | 4'b1000)));
    end
    checks++;
    if (hrq !== 1'b0 || aen !== 1'b0 || dack_n !== 1'b1) begin
      failures++;
      $display("FAIL %s_idle hrq=%b aen=%b dack_n=%b required 0 0 1", name, hrq, aen, dack_n);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({hrq, dack_n, tc, aen, ior_n, iow_n, memr_n, memw_n} !== 8'b0100_1111 || a !== 20'h0) begin
      failures++;
      $display("FAIL %s_outputs got=%b a=%h required=01001111 a=00000", name,
               {hrq, dack_n, tc, aen, ior_n, iow_n, memr_n, memw_n}, a);
    end
  endtask

  task automatic test_reset();
    logic [15:0] d;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk); #1;
    for (int r = 0; r < 3; r++) begin
      rd(2'(r), d);
      checks++;
      if (d !== 16'h0000) begin
        failures++;
        $display("FAIL reset_reg%0d got=%h required=0000", r, d);
      end
    end
    rd(2'd3, d);
    checks++;
    if (d !== 16'h0008) begin
      failures++;
      $display("FAIL reset_mode got=%h required=0008", d);
    end
  endtask

  task automatic test_basic();
    run_block("basic", 16'h1000, 16'd2, 4'h3, 4'b0000);
  endtask

  task automatic test_status();
    logic [15:0] d;
    logic        exp_seen;
`ifdef DMA_STATUS_EN
    exp_seen = 1'b1;
`else
    exp_seen = 1'b0;
`endif
    rd(2'd3, d);
    checks++;
    if (d[15:8] !== {7'b0, exp_seen}) begin
      failures++;
      $display("FAIL status_after_tc got=%h required=%h", d[15:8], {7'b0, exp_seen});
    end
    wr(2'd3, 16'h0008);
    rd(2'd3, d);
    checks++;
    if (d[15:8] !== 8'h00) begin
      failures++;
      $display("FAIL status_cleared got=%h required=00", d[15:8]);
    end
  endtask

  task automatic test_autoinit();
    run_block("autoinit", 16'hFFFF, 16'd0, 4'h5, 4'b0011);
  endtask

  task automatic test_wrap();
    run_block("wrap", 16'h0000, 16'd1, 4'h0, 4'b0100);
  endtask

  task automatic test_random();
    logic [15:0] base;
    for (int k = 0; k < 6; k++) begin
      case ($urandom_range(0, 2))
        0:       base = 16'hFFFE;
        1:       base = 16'h0001;
        default: base = 16'($urandom);
      endcase
      run_block("random", base, 16'($urandom_range(0, 4)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 7)));
    end
  endtask

  task automatic test_drq_abort();
    logic [15:0] d;
    int cyc;
    hlda_en = 1'b0;
    drq = 1'b0;
    wr(2'd0, 16'h2000);
    wr(2'd1, 16'd3);
    wr(2'd2, 16'h0001);
    wr(2'd3, 16'h0000);
    @(negedge clk); #1;
    clear_q();
    drq = 1'b1;
    cyc = 0;
    while (hrq !== 1'b1 && cyc < 20) begin
      @(negedge clk); #1;
      cyc++;
    end
    checks++;
    if (hrq !== 1'b1 || aen !== 1'b0 || dack_n !== 1'b1) begin
      failures++;
      $display("FAIL drq_req_wait hrq=%b aen=%b dack_n=%b required 1 0 1", hrq, aen, dack_n);
    end
    drq = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (hrq !== 1'b0 || aen !== 1'b0 || dack_n !== 1'b1) begin
      failures++;
      $display("FAIL drq_req_drop hrq=%b aen=%b dack_n=%b required 0 0 1", hrq, aen, dack_n);
    end
    hlda_en = 1'b1;
    drq = 1'b1;
    cyc = 0;
    while ((ior_n & memw_n) === 1'b1 && cyc < 50) begin
      @(negedge clk); #1;
      cyc++;
    end
    drq = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    checks++;
    if (q_len.size() != 1) begin
      failures++;
      $display("FAIL drq_xfer_bytes got=%0d required=1", q_len.size());
    end
    rd(2'd1, d);
    checks++;
    if (d !== 16'd2) begin
      failures++;
      $display("FAIL drq_xfer_count got=%h required=0002", d);
    end
    rd(2'd0, d);
    checks++;
    if (d !== 16'h2001) begin
      failures++;
      $display("FAIL drq_xfer_addr got=%h required=2001", d);
    end
    checks++;
    if (hrq !== 1'b0) begin
      failures++;
      $display("FAIL drq_xfer_idle hrq=%b required=0", hrq);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] d;
    int cyc;
    wr(2'd0, 16'h4000);
    wr(2'd1, 16'd3);
    wr(2'd3, 16'h0001);
    drq = 1'b1;
    cyc = 0;
    while ((memr_n & iow_n) === 1'b1 && cyc < 50) begin
      @(negedge clk); #1;
      cyc++;
    end
    checks++;
    if (memr_n !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_reach_xfer memr_n=%b required=0", memr_n);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rstmid");
    rd(2'd3, d);
    checks++;
    if (d[3:0] !== 4'b1000) begin
      failures++;
      $display("FAIL rstmid_mode got=%b required=1000", d[3:0]);
    end
    drq = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    reg_wr    = 1'b0;
    reg_addr  = 2'd0;
    reg_wdata = 16'h0;
    drq       = 1'b0;
    hlda_en   = 1'b1;
    test_reset();
    test_basic();
    test_status();
    test_autoinit();
    test_wrap();
    test_random();
    test_drq_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
